// File: rtl/fib_pkg.sv
// fib_pkg: definitions shared by fibonacci_counter and its consumers.
//  FIB_W       width of the Fibonacci result word
//  FIB_N_W     width of the sequence index n
//  BCD_DIGITS  decimal digits needed to show a FIB_W-bit value
//  bcd_state_t control states of the binary-to-BCD converter
package fib_pkg;

  localparam int FIB_W      = 32;
  localparam int FIB_N_W    = 6;
  localparam int BCD_DIGITS = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble correction for one BCD digit.
// If the digit is 5 or more, add 3, so that the following left shift
// carries correctly into the next decimal digit.
//  d  in   4  digit before the shift
//  q  out  4  corrected digit
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // The input never exceeds 9, so the result stays within 4 bits (max 12).
  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/fib_bin2bcd.sv
// fib_bin2bcd: sequential binary-to-BCD converter (shift-add-3).
// Converts one bit per clock, with a start/busy/done handshake.
//  clk    in   1         rising-edge clock
//  rst    in   1         asynchronous active-high reset
//  start  in   1         conversion request, honoured only while idle
//  bin    in   BIN_W     binary value, captured when start is accepted
//  busy   out  1         high while converting and during the done cycle
//  done   out  1         one-cycle pulse; bcd is valid from this cycle on
//  bcd    out  4*DIGITS  packed BCD, units digit in [3:0], held until the next done
module fib_bin2bcd
  import fib_pkg::*;
#(
  parameter int BIN_W  = FIB_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  bcd_state_t         state_reg, state_next;
  logic [BIN_W-1:0]   shreg_reg;
  logic [BCD_W-1:0]   work_reg;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_shift;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [BCD_W-1:0]   bcd_reg;

  // Every digit is corrected in parallel before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .d (work_reg[4*gi +: 4]),
        .q (work_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Upper half of {work_adj, shreg} << 1: the binary MSB enters digit bit 0.
  assign work_shift = {work_adj[BCD_W-2:0], shreg_reg[BIN_W-1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      work_reg  <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      bcd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Flags are registered from the next state so they line up with it
      // and leave no combinational path from the inputs.
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            shreg_reg <= bin;
            work_reg  <= '0;
            cnt_reg   <= '0;
          end
        end
        CONVERT: begin
          work_reg  <= work_shift;
          shreg_reg <= {shreg_reg[BIN_W-2:0], 1'b0};
          cnt_reg   <= cnt_reg + 1'b1;
          // Publish only the complete result, so bcd never shows partial values.
          if (cnt_reg == LAST_BIT) bcd_reg <= work_shift;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;

endmodule

// File: tb/tb_fib_bin2bcd.sv
module tb_fib_bin2bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bin = '0;
  logic        busy;
  logic        done;
  logic [39:0] bcd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [39:0] bcd;
    int          cyc;
    logic [31:0] bin;
  } exp_t;

  exp_t sb[$];

  fib_bin2bcd #(.BIN_W(32), .DIGITS(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal reference: print the value in decimal and pack the characters.
  function automatic logic [39:0] bcd_of(input logic [31:0] v);
    string       s;
    logic [39:0] r;
    s = $sformatf("%0d", v);
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      r = (r << 4) | 40'(s[i] - 8'd48);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still %b after 200 cycles, required 0", busy);
    end
  endtask

  // Start one conversion on the current idle negedge; accept happens on the next edge.
  task automatic issue(input logic [31:0] v, input logic [39:0] exp);
    exp_t e;
    wait_idle();
    start = 1'b1;
    bin   = v;
    e.bcd = exp;
    e.cyc = cyc + 33;
    e.bin = v;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done=1 at cycle %0d bcd=%h, required no done", cyc, bcd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("bcd(bin=%0d)", e.bin), bcd, e.bcd);
        check($sformatf("done_cycle(bin=%0d)", e.bin), 40'(cyc), 40'(e.cyc));
      end
    end
  end

  typedef struct {
    logic [31:0] bin;
    logic [39:0] bcd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] fa, fb, fn;
    exp_t        e;
    int          k;

    vecs[0] = '{32'd0,          40'h0};
    vecs[1] = '{32'd1134903170, 40'h1134903170};
    vecs[2] = '{32'd10946,      40'h0000010946};
    vecs[3] = '{32'hFFFFFFFF,   40'h4294967295};
    vecs[4] = '{32'd9,          40'h9};
    vecs[5] = '{32'd10,         40'h10};

    // Reset held for two cycles, then released.
    repeat (2) @(negedge clk);
    check("rst_busy", 40'(busy), 40'h0);
    check("rst_done", 40'(done), 40'h0);
    check("rst_bcd",  bcd,       40'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_bcd", bcd, 40'h0);

    // Directed vectors.
    foreach (vecs[i]) issue(vecs[i].bin, vecs[i].bcd);

    // Fibonacci sweep n=0..47 against the decimal reference.
    fa = 32'd0;
    fb = 32'd1;
    for (int n = 0; n < 48; n++) begin
      issue(fa, bcd_of(fa));
      fn = fa + fb;
      fa = fb;
      fb = fn;
    end

    // Start pulse mid-conversion must be ignored: only one result, for 55.
    issue(32'd55, 40'h55);
    repeat (10) @(negedge clk);
    start = 1'b1;
    bin   = 32'd99;
    @(negedge clk);
    start = 1'b0;
    bin   = 32'd0;

    // Start held high: back-to-back conversions BIN_W+2 cycles apart, bin re-sampled.
    wait_idle();
    k = cyc;
    start = 1'b1;
    bin   = 32'd233;
    e = '{40'h233, k + 33, 32'd233};
    sb.push_back(e);
    @(negedge clk);
    bin = 32'd4181;
    e = '{40'h4181, k + 33 + 34, 32'd4181};
    sb.push_back(e);
    repeat (34) @(negedge clk);
    bin = 32'd832040;
    e = '{40'h832040, k + 33 + 68, 32'd832040};
    sb.push_back(e);
    repeat (34) @(negedge clk);
    start = 1'b0;

    // Asynchronous reset in the middle of a conversion: no done, outputs clear at once.
    wait_idle();
    start = 1'b1;
    bin   = 32'd12345;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 40'(busy), 40'h0);
    check("abort_done", 40'(done), 40'h0);
    check("abort_bcd",  bcd,       40'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd777, 40'h777);

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 40'(sb.size()), 40'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
